// File: rtl/axi4_lite_mem_slv.sv
// axi4_lite_mem_slv
// AXI4-Lite responder holding a word-addressed SRAM, a write-only console byte
// port and a sticky test-status flag. Read and write channels run as two
// independent FSMs, each with at most one transaction outstanding.
//
// Handshake rule (all five channels): a transfer happens on a rising clk edge
// where both valid and ready are 1. A source holds valid and its payload
// stable until that edge. Ready outputs here are registered and depend only on
// FSM state, never combinationally on the valid inputs.
//
// Timing as seen on the bus:
//   write: bvalid rises two edges after the edge completing both AW and W;
//          the SRAM, console and status updates happen on the first of them.
//   read : rvalid rises exactly RD_LAT edges after the AR handshake edge;
//          rdata is captured from the SRAM on that same edge, so a write
//          committing on it to the same word is not yet visible.
//
// Debug outputs: wr_state_dbg encodes WIDLE=0 WHAVE_AW=1 WHAVE_W=2 WCOMMIT=3
// WRESP=4; rd_state_dbg encodes RIDLE=0 RWAIT=1 RRESP=2.
module axi4_lite_mem_slv #(
    parameter int unsigned MEM_WORDS    = 32768,
    parameter int unsigned RD_LAT       = 1,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
    parameter logic [31:0] PASS_VALUE   = 32'd123456789
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,
    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,
    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,
    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,
    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata,
    output logic        console_valid,
    output logic [7:0]  console_data,
    output logic        tests_passed,
    output logic [2:0]  wr_state_dbg,
    output logic [1:0]  rd_state_dbg
);

    localparam int unsigned AW     = $clog2(MEM_WORDS);
    localparam logic [3:0]  LAT_M1 = 4'(RD_LAT - 1);
    localparam logic [29:0] CONSOLE_WORD = CONSOLE_ADDR[31:2];
    localparam logic [29:0] PASS_WORD    = PASS_ADDR[31:2];

    typedef enum logic [2:0] {
        WIDLE    = 3'd0,
        WHAVE_AW = 3'd1,
        WHAVE_W  = 3'd2,
        WCOMMIT  = 3'd3,
        WRESP    = 3'd4
    } wr_state_t;

    typedef enum logic [1:0] {
        RIDLE = 2'd0,
        RWAIT = 2'd1,
        RRESP = 2'd2
    } rd_state_t;

    // Storage; contents survive reset.
    logic [31:0] mem [MEM_WORDS];

    // ---------------------------------------------------------------- write
    wr_state_t   wr_state;
    wr_state_t   wr_next;
    logic        aw_hs;
    logic        w_hs;
    logic [29:0] wr_word;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_commit;
    logic        wr_is_console;
    logic        wr_is_pass;
    logic        wr_in_mem;
    logic        mem_we;
    logic [AW-1:0] wr_idx;

    assign aw_hs = mem_axi_awvalid && mem_axi_awready;
    assign w_hs  = mem_axi_wvalid && mem_axi_wready;

    // Decode of the latched write address, console first, then status, then SRAM.
    assign wr_commit     = (wr_state == WCOMMIT);
    assign wr_is_console = (wr_word == CONSOLE_WORD);
    assign wr_is_pass    = (wr_word == PASS_WORD);
    assign wr_in_mem     = ({2'b00, wr_word} < MEM_WORDS);
    assign mem_we        = wr_commit && !wr_is_console && !wr_is_pass && wr_in_mem;
    assign wr_idx        = wr_word[AW-1:0];

    // Write FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state <= WIDLE;
        end else begin
            wr_state <= wr_next;
        end
    end

    // Write FSM next state: AW and W may arrive together or in either order.
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WIDLE: begin
                if (aw_hs && w_hs) begin
                    wr_next = WCOMMIT;
                end else if (aw_hs) begin
                    wr_next = WHAVE_AW;
                end else if (w_hs) begin
                    wr_next = WHAVE_W;
                end
            end
            WHAVE_AW: begin
                if (w_hs) begin
                    wr_next = WCOMMIT;
                end
            end
            WHAVE_W: begin
                if (aw_hs) begin
                    wr_next = WCOMMIT;
                end
            end
            WCOMMIT: begin
                wr_next = WRESP;
            end
            WRESP: begin
                if (mem_axi_bvalid && mem_axi_bready) begin
                    wr_next = WIDLE;
                end
            end
            default: begin
                wr_next = WIDLE;
            end
        endcase
    end

    // Write-side registered outputs, payload latches and side effects of a commit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_axi_awready <= 1'b0;
            mem_axi_wready  <= 1'b0;
            mem_axi_bvalid  <= 1'b0;
            wr_word         <= '0;
            wr_data         <= '0;
            wr_strb         <= '0;
            console_valid   <= 1'b0;
            console_data    <= '0;
            tests_passed    <= 1'b0;
        end else begin
            mem_axi_awready <= (wr_next == WIDLE) || (wr_next == WHAVE_W);
            mem_axi_wready  <= (wr_next == WIDLE) || (wr_next == WHAVE_AW);
            if (aw_hs) begin
                wr_word <= mem_axi_awaddr[31:2];
            end
            if (w_hs) begin
                wr_data <= mem_axi_wdata;
                wr_strb <= mem_axi_wstrb;
            end
            // bvalid is raised on the first edge spent in WRESP.
            if (wr_state == WRESP && !mem_axi_bvalid) begin
                mem_axi_bvalid <= 1'b1;
            end else if (mem_axi_bvalid && mem_axi_bready) begin
                mem_axi_bvalid <= 1'b0;
            end
            console_valid <= wr_commit && wr_is_console;
            if (wr_commit && wr_is_console) begin
                console_data <= wr_data[7:0];
            end
            if (wr_commit && !wr_is_console && wr_is_pass && (wr_data == PASS_VALUE)) begin
                tests_passed <= 1'b1;
            end
        end
    end

    // Byte-masked SRAM write; a zero strobe leaves the word untouched.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // ----------------------------------------------------------------- read
    rd_state_t   rd_state;
    rd_state_t   rd_next;
    logic        ar_hs;
    logic [29:0] rd_word;
    logic [3:0]  rd_cnt;
    logic        rd_hit;
    logic [AW-1:0] rd_idx;

    assign ar_hs  = mem_axi_arvalid && mem_axi_arready;
    assign rd_hit = (rd_word != CONSOLE_WORD) && (rd_word != PASS_WORD)
                    && ({2'b00, rd_word} < MEM_WORDS);
    assign rd_idx = rd_word[AW-1:0];

    // Read FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state <= RIDLE;
        end else begin
            rd_state <= rd_next;
        end
    end

    // Read FSM next state: RWAIT burns the extra latency, leaving it as the count hits zero.
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RIDLE: begin
                if (ar_hs) begin
                    rd_next = (RD_LAT > 1) ? RWAIT : RRESP;
                end
            end
            RWAIT: begin
                if (rd_cnt == 4'd1) begin
                    rd_next = RRESP;
                end
            end
            RRESP: begin
                if (mem_axi_rvalid && mem_axi_rready) begin
                    rd_next = RIDLE;
                end
            end
            default: begin
                rd_next = RIDLE;
            end
        endcase
    end

    // Read-side registered outputs, address latch, latency counter and data capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_axi_arready <= 1'b0;
            mem_axi_rvalid  <= 1'b0;
            mem_axi_rdata   <= '0;
            rd_word         <= '0;
            rd_cnt          <= '0;
        end else begin
            mem_axi_arready <= (rd_next == RIDLE);
            if (ar_hs) begin
                rd_word <= mem_axi_araddr[31:2];
                rd_cnt  <= LAT_M1;
            end else if (rd_state == RWAIT) begin
                rd_cnt <= rd_cnt - 4'd1;
            end
            // Capture once on the first edge in RRESP, then hold until accepted.
            if (rd_state == RRESP && !mem_axi_rvalid) begin
                mem_axi_rvalid <= 1'b1;
                mem_axi_rdata  <= rd_hit ? mem[rd_idx] : 32'd0;
            end else if (mem_axi_rvalid && mem_axi_rready) begin
                mem_axi_rvalid <= 1'b0;
            end
        end
    end

    assign wr_state_dbg = wr_state;
    assign rd_state_dbg = rd_state;

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{mem_axi_awprot, mem_axi_arprot,
                           mem_axi_awaddr[1:0], mem_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi4_lite_mem_slv.sv
// Bench for axi4_lite_mem_slv: one instance with RD_LAT=1 for the main checks
// and a small RD_LAT=4 instance for read-latency corner cases.
module tb_axi4_lite_mem_slv;

  localparam int unsigned MEM_WORDS    = 32768;
  localparam int unsigned D4_WORDS     = 256;
  localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] PASS_ADDR    = 32'h2000_0000;
  localparam logic [31:0] PASS_VALUE   = 32'd123456789;

  // ---------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------- dut1 (RD_LAT=1)
  logic        awvalid = 0, awready;
  logic [31:0] awaddr = 0;
  logic        wvalid = 0, wready;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        bvalid, bready = 0;
  logic        arvalid = 0, arready;
  logic [31:0] araddr = 0;
  logic        rvalid, rready = 0;
  logic [31:0] rdata;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        tests_passed;
  logic [2:0]  wr_state_dbg;
  logic [1:0]  rd_state_dbg;

  axi4_lite_mem_slv #(.MEM_WORDS(MEM_WORDS), .RD_LAT(1)) u_dut (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
    .mem_axi_awprot(3'b000),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata),
    .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr),
    .mem_axi_arprot(3'b000),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata),
    .console_valid(console_valid), .console_data(console_data),
    .tests_passed(tests_passed),
    .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
  );

  // ------------------------------------------------------- dut4 (RD_LAT=4)
  logic        d4_awvalid = 0, d4_awready;
  logic [31:0] d4_awaddr = 0;
  logic        d4_wvalid = 0, d4_wready;
  logic [31:0] d4_wdata = 0;
  logic        d4_bvalid, d4_bready = 0;
  logic        d4_arvalid = 0, d4_arready;
  logic [31:0] d4_araddr = 0;
  logic        d4_rvalid, d4_rready = 0;
  logic [31:0] d4_rdata;
  logic        d4_console_valid;
  logic [7:0]  d4_console_data;
  logic        d4_tests_passed;
  logic [2:0]  d4_wr_state_dbg;
  logic [1:0]  d4_rd_state_dbg;

  axi4_lite_mem_slv #(.MEM_WORDS(D4_WORDS), .RD_LAT(4)) u_dut4 (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(d4_awvalid), .mem_axi_awready(d4_awready), .mem_axi_awaddr(d4_awaddr),
    .mem_axi_awprot(3'b000),
    .mem_axi_wvalid(d4_wvalid), .mem_axi_wready(d4_wready), .mem_axi_wdata(d4_wdata),
    .mem_axi_wstrb(4'hF),
    .mem_axi_bvalid(d4_bvalid), .mem_axi_bready(d4_bready),
    .mem_axi_arvalid(d4_arvalid), .mem_axi_arready(d4_arready), .mem_axi_araddr(d4_araddr),
    .mem_axi_arprot(3'b000),
    .mem_axi_rvalid(d4_rvalid), .mem_axi_rready(d4_rready), .mem_axi_rdata(d4_rdata),
    .console_valid(d4_console_valid), .console_data(d4_console_data),
    .tests_passed(d4_tests_passed),
    .wr_state_dbg(d4_wr_state_dbg), .rd_state_dbg(d4_rd_state_dbg)
  );

  // ------------------------------------------------ scoreboard and model
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [int unsigned];
  logic        exp_passed = 1'b0;
  int          con_cnt = 0;
  logic [7:0]  con_last = 8'h00;

  always @(negedge clk) begin
    if (console_valid) begin
      con_cnt  <= con_cnt + 1;
      con_last <= console_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of a committed write, from the address map.
  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    int unsigned word = addr / 4;
    if (word == CONSOLE_ADDR / 4) return;
    if (word == PASS_ADDR / 4) begin
      if (data == PASS_VALUE) exp_passed = 1'b1;
      return;
    end
    if (word >= MEM_WORDS) return;
    if (!ref_mem.exists(word)) begin
      if (strb == 4'hF) ref_mem[word] = data;
      return;
    end
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) ref_mem[word][8*b +: 8] = data[8*b +: 8];
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int unsigned word = addr / 4;
    if (word == CONSOLE_ADDR / 4 || word == PASS_ADDR / 4 || word >= MEM_WORDS) return 32'd0;
    if (ref_mem.exists(word)) return ref_mem[word];
    return 32'hxxxx_xxxx;
  endfunction

  // ---------------------------------------------------------- dut1 driver
  // aw_start/w_start: cycle offsets at which each channel raises valid.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_start, input int w_start,
                           input int bdelay);
    bit aw_pend = 1, w_pend = 1, aw_fire, w_fire;
    int c = 0;
    int lat = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while ((aw_pend || w_pend) && c < 40) begin
      awvalid = aw_pend && (c >= aw_start);
      wvalid  = w_pend && (c >= w_start);
      @(negedge clk);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_fire) aw_pend = 0;
      if (w_fire) w_pend = 0;
      c++;
    end
    awvalid = 0; wvalid = 0;
    check("aw_w_handshake", {30'd0, aw_pend, w_pend}, 32'd0);
    if (aw_pend || w_pend) return;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bvalid && lat < 20);
    check("b_latency", 32'(lat), 32'd2);
    for (int i = 0; i < bdelay; i++) begin
      @(posedge clk); #1;
      check("bvalid_hold", 32'(bvalid), 32'd1);
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    check("bvalid_drop", 32'(bvalid), 32'd0);
    check("aw_w_ready_back", {30'd0, awready, wready}, 32'd3);
  endtask

  // When chk is set the expected data is taken from the front of exp_q.
  task automatic axi_read(input logic [31:0] addr, input int rdelay, input bit chk);
    bit fire = 0;
    int c = 0;
    int lat = 0;
    logic [31:0] exp = 32'd0;
    if (chk) exp = exp_q.pop_front();
    araddr = addr; arvalid = 1;
    do begin
      @(negedge clk);
      fire = arready;
      @(posedge clk); #1;
      c++;
    end while (!fire && c < 40);
    arvalid = 0;
    check("ar_handshake", 32'(fire), 32'd1);
    if (!fire) return;
    while (!rvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("r_latency", 32'(lat), 32'd1);
    if (chk) check("rdata", rdata, exp);
    for (int i = 0; i < rdelay; i++) begin
      @(posedge clk); #1;
      check("rvalid_hold", 32'(rvalid), 32'd1);
      if (chk) check("rdata_hold", rdata, exp);
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    check("rvalid_drop", 32'(rvalid), 32'd0);
  endtask

  // ---------------------------------------------------------- dut4 driver
  task automatic d4_write(input logic [31:0] addr, input logic [31:0] data);
    bit f = 0;
    int c = 0;
    d4_awaddr = addr; d4_wdata = data; d4_awvalid = 1; d4_wvalid = 1;
    do begin
      @(negedge clk);
      f = d4_awready && d4_wready;
      @(posedge clk); #1;
      c++;
    end while (!f && c < 20);
    d4_awvalid = 0; d4_wvalid = 0;
    d4_bready = 1;
    c = 0;
    do begin
      @(negedge clk);
      f = d4_bvalid;
      @(posedge clk); #1;
      c++;
    end while (!f && c < 20);
    d4_bready = 0;
    check("d4_write_done", 32'(f), 32'd1);
  endtask

  task automatic d4_read(input logic [31:0] addr, input logic [31:0] exp, input int rdelay);
    bit f = 0;
    int c = 0;
    int lat = 0;
    d4_araddr = addr; d4_arvalid = 1;
    do begin
      @(negedge clk);
      f = d4_arready;
      @(posedge clk); #1;
      c++;
    end while (!f && c < 20);
    d4_arvalid = 0;
    check("d4_ar_handshake", 32'(f), 32'd1);
    if (!f) return;
    check("d4_arready_low", 32'(d4_arready), 32'd0);
    while (!d4_rvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("d4_r_latency", 32'(lat), 32'd4);
    check("d4_rdata", d4_rdata, exp);
    for (int i = 0; i < rdelay; i++) begin
      @(posedge clk); #1;
      check("d4_rdata_hold", d4_rdata, exp);
      check("d4_arready_hold", 32'(d4_arready), 32'd0);
    end
    d4_rready = 1;
    @(posedge clk); #1;
    d4_rready = 0;
    check("d4_rvalid_drop", 32'(d4_rvalid), 32'd0);
    check("d4_arready_back", 32'(d4_arready), 32'd1);
  endtask

  // ---------------------------------------------------------- vector table
  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_start;
    int          w_start;
    int          dly;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  // Watchdog: the drivers are bounded, this only guards against a stuck bench.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int c0;

    // Expected read values are written out by hand from the address map.
    vecs[0]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 3, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 0, 0, 0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0040, 32'h0000_00AA, 4'h1, 2, 0, 0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 0, 0, 2, 32'hDEAD_BEAA};
    vecs[4]  = '{1'b1, 32'h0000_0044, 32'h1122_3344, 4'hF, 0, 2, 1, 32'h0};
    vecs[5]  = '{1'b1, 32'h0000_0044, 32'hAABB_CCDD, 4'hA, 0, 0, 0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0046, 32'h0,         4'h0, 0, 0, 0, 32'hAA22_CC44};
    vecs[7]  = '{1'b1, 32'h0000_0045, 32'hFFFF_FFFF, 4'h0, 1, 1, 0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0044, 32'h0,         4'h0, 0, 0, 0, 32'hAA22_CC44};
    vecs[9]  = '{1'b1, 32'h0002_0000, 32'h1234_5678, 4'hF, 0, 0, 0, 32'h0};
    vecs[10] = '{1'b0, 32'h0002_0000, 32'h0,         4'h0, 0, 0, 0, 32'h0};
    vecs[11] = '{1'b1, 32'h0001_FFFC, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 32'h0};
    vecs[12] = '{1'b0, 32'h0001_FFFF, 32'h0,         4'h0, 0, 0, 1, 32'hCAFE_F00D};
    vecs[13] = '{1'b0, CONSOLE_ADDR,  32'h0,         4'h0, 0, 0, 0, 32'h0};

    // Reset: three cycles low, outputs all zero, readies one edge after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(|{awready, wready, bvalid, arready, rvalid, rdata,
                                 console_valid, console_data, tests_passed}), 32'd0);
    @(posedge clk); #1;
    resetn = 1;
    check("ready_before_edge", {29'd0, awready, wready, arready}, 32'd0);
    @(posedge clk); #1;
    check("ready_after_release", {29'd0, awready, wready, arready}, 32'd7);
    check("d4_ready_after_release", {29'd0, d4_awready, d4_wready, d4_arready}, 32'd7);

    // Table of writes and reads.
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) begin
        model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb,
                  vecs[i].aw_start, vecs[i].w_start, vecs[i].dly);
      end else begin
        exp_q.push_back(vecs[i].exp);
        axi_read(vecs[i].addr, vecs[i].dly, 1'b1);
      end
    end
    exp_q.push_back(32'd0);
    axi_read(PASS_ADDR, 0, 1'b1);

    // Console byte port and status flag.
    c0 = con_cnt;
    axi_write(CONSOLE_ADDR, 32'h0000_0041, 4'hF, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("console_pulses", 32'(con_cnt - c0), 32'd1);
    check("console_data", {24'd0, con_last}, 32'h41);
    check("console_idle", 32'(console_valid), 32'd0);
    model_write(PASS_ADDR, 32'd5, 4'hF);
    axi_write(PASS_ADDR, 32'd5, 4'hF, 0, 0, 0);
    check("pass_wrong_value", 32'(tests_passed), 32'(exp_passed));
    model_write(PASS_ADDR, PASS_VALUE, 4'hF);
    axi_write(PASS_ADDR, PASS_VALUE, 4'h1, 1, 0, 0);
    check("pass_set", 32'(tests_passed), 32'(exp_passed));
    model_write(PASS_ADDR, 32'd0, 4'hF);
    axi_write(PASS_ADDR, 32'd0, 4'hF, 0, 0, 0);
    check("pass_sticky", 32'(tests_passed), 32'd1);

    // Read/write collision on word 0x80: the read sees the old data.
    model_write(32'h80, 32'h1111_1111, 4'hF);
    axi_write(32'h80, 32'h1111_1111, 4'hF, 0, 0, 0);
    awaddr = 32'h80; wdata = 32'h2222_2222; wstrb = 4'hF; araddr = 32'h80;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge clk);
    check("collide_readies", {29'd0, awready, wready, arready}, 32'd7);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(posedge clk); #1;
    check("collide_rvalid", 32'(rvalid), 32'd1);
    check("collide_old_data", rdata, 32'h1111_1111);
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    check("collide_bvalid", 32'(bvalid), 32'd1);
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    model_write(32'h80, 32'h2222_2222, 4'hF);
    exp_q.push_back(model_read(32'h80));
    axi_read(32'h80, 0, 1'b1);

    // Randomized traffic on a pool of eight words against the reference model.
    for (int k = 0; k < 8; k++) begin
      a = 32'h100 + 32'(4 * k);
      d = $urandom;
      model_write(a, d, 4'hF);
      axi_write(a, d, 4'hF, 0, 0, 0);
    end
    for (int n = 0; n < 40; n++) begin
      a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        wstrb = 4'($urandom_range(0, 15));
        model_write(a, d, wstrb);
        axi_write(a, d, wstrb, $urandom_range(0, 2), $urandom_range(0, 2),
                  $urandom_range(0, 2));
      end else begin
        exp_q.push_back(model_read(a));
        axi_read(a, $urandom_range(0, 2), 1'b1);
      end
    end

    // RD_LAT=4 instance: latency, held data, arready low until the R handshake.
    d4_write(32'h40, 32'h5A5A_1234);
    d4_read(32'h40, 32'h5A5A_1234, 2);
    d4_read(32'(D4_WORDS * 4), 32'd0, 1);

    // Reset while holding only the write address: the write is abandoned.
    awaddr = 32'h40; wdata = 32'h0BAD_0BAD; wstrb = 4'hF; awvalid = 1;
    @(negedge clk);
    check("rst_aw_ready", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 0;
    check("in_whave_aw", {29'd0, wr_state_dbg}, 32'd1);
    resetn = 0;
    #1;
    check("async_reset_outputs", 32'(|{awready, wready, bvalid, arready, tests_passed}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1;
    exp_passed = 1'b0;
    @(posedge clk); #1;
    check("rst_wr_state_idle", {29'd0, wr_state_dbg}, 32'd0);
    check("rst_readies", {29'd0, awready, wready, arready}, 32'd7);
    check("rst_pass_cleared", 32'(tests_passed), 32'(exp_passed));
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_bvalid", 32'(bvalid), 32'd0);
    exp_q.push_back(model_read(32'h40));
    axi_read(32'h40, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
